// File: rtl/mygo_chan_pkg.sv
// Shared sizing helpers and defaults for the mygo buffered channel.
package mygo_chan_pkg;

  localparam int MYGO_WIDTH_DEF = 32;
  localparam int MYGO_DEPTH_DEF = 4;

  // A one-entry channel still needs a 1-bit pointer to keep port widths legal.
  function automatic int mygo_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int mygo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mygo_chan_mem.sv
// Channel storage: one synchronous write port, one asynchronous read port, no reset on contents.
module mygo_chan_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mygo_chan_fifo.sv
// Buffered FWFT channel with Go-style close, occupancy flags and sticky misuse errors.
module mygo_chan_fifo
  import mygo_chan_pkg::*;
#(
  parameter int WIDTH      = MYGO_WIDTH_DEF,
  parameter int DEPTH      = MYGO_DEPTH_DEF,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [WIDTH-1:0]              i_in_data,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic                          i_in_close,
  output logic [WIDTH-1:0]              o_out_data,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic                          o_out_closed,
  output logic [mygo_cnt_w(DEPTH)-1:0]  o_count,
  output logic                          o_almost_full,
  output logic                          o_almost_empty,
  output logic                          o_err_send_closed,
  output logic                          o_err_double_close
);

  localparam int PTR_W = mygo_ptr_w(DEPTH);
  localparam int CNT_W = mygo_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] L_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] L_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_closed;
  logic             r_err_send_closed;
  logic             r_err_double_close;

  logic             w_push;
  logic             w_pop;
  logic             w_in_ready;
  logic             w_not_empty;
  logic [WIDTH-1:0] w_rdata;

  // in_ready depends only on registered state, so a pop never frees a slot for
  // a push in the same cycle when full.
  assign w_in_ready  = (r_count < L_FULL) && !r_closed;
  assign w_not_empty = (r_count != '0);
  assign w_push      = i_in_valid && w_in_ready;
  assign w_pop       = w_not_empty && i_out_ready;

  mygo_chan_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr           <= '0;
      r_rd_ptr           <= '0;
      r_count            <= '0;
      r_closed           <= 1'b0;
      r_err_send_closed  <= 1'b0;
      r_err_double_close <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + 1'b1;

      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;

      if (i_in_close) r_closed <= 1'b1;
      if (i_in_valid && r_closed) r_err_send_closed  <= 1'b1;
      if (i_in_close && r_closed) r_err_double_close <= 1'b1;
    end
  end

  assign o_in_ready         = w_in_ready;
  assign o_out_valid        = w_not_empty;
  // Storage has no reset, so hide stale contents while empty.
  assign o_out_data         = w_not_empty ? w_rdata : '0;
  assign o_out_closed       = r_closed && !w_not_empty;
  assign o_count            = r_count;
  assign o_almost_full      = int'(r_count) >= AFULL_LVL;
  assign o_almost_empty     = int'(r_count) <= AEMPTY_LVL;
  assign o_err_send_closed  = r_err_send_closed;
  assign o_err_double_close = r_err_double_close;

endmodule

// File: tb/tb_mygo_chan_fifo.sv
// Directed bench for mygo_chan_fifo: a 32x4 instance and an 8x3 instance share clock and reset.
module tb_mygo_chan_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] a_in_data = '0;
  logic        a_in_valid = 1'b0, a_in_close = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_out_data;
  logic        a_in_ready, a_out_valid, a_out_closed, a_afull, a_aempty, a_esc, a_edc;
  logic [2:0]  a_count;

  logic [7:0]  b_in_data = '0;
  logic        b_in_valid = 1'b0, b_in_close = 1'b0, b_out_ready = 1'b0;
  logic [7:0]  b_out_data;
  logic        b_in_ready, b_out_valid, b_out_closed, b_afull, b_aempty, b_esc, b_edc;
  logic [1:0]  b_count;

  mygo_chan_fifo #(.WIDTH(32), .DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_in_data(a_in_data), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_in_close(a_in_close),
    .o_out_data(a_out_data), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
    .o_out_closed(a_out_closed), .o_count(a_count),
    .o_almost_full(a_afull), .o_almost_empty(a_aempty),
    .o_err_send_closed(a_esc), .o_err_double_close(a_edc)
  );

  mygo_chan_fifo #(.WIDTH(8), .DEPTH(3)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_in_data(b_in_data), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_in_close(b_in_close),
    .o_out_data(b_out_data), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
    .o_out_closed(b_out_closed), .o_count(b_count),
    .o_almost_full(b_afull), .o_almost_empty(b_aempty),
    .o_err_send_closed(b_esc), .o_err_double_close(b_edc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [9:0] v_push;
    bit [9:0] v_pop;
    int nxt;
    int exp_rd;
    int cnt;

    v_push = 10'b1101011101;
    v_pop  = 10'b0110110110;

    // reset
    tick(); tick();
    rst = 1'b0;
    check("rst_count",  32'(a_count), 0);
    check("rst_valid",  32'(a_out_valid), 0);
    check("rst_data",   a_out_data, 0);
    check("rst_closed", 32'(a_out_closed), 0);
    check("rst_afull",  32'(a_afull), 0);
    check("rst_aempty", 32'(a_aempty), 1);
    check("rst_ready",  32'(a_in_ready), 1);
    check("rst_esc",    32'(a_esc), 0);
    check("rst_edc",    32'(a_edc), 0);
    check("b_rst_count", 32'(b_count), 0);

    // DEPTH=3: interleaved traffic holding occupancy at 1..2
    b_in_data = 8'h40; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    nxt = 8'h41; exp_rd = 8'h40; cnt = 1;
    check("b_first_count", 32'(b_count), 1);
    for (int i = 0; i < 10; i++) begin
      b_in_valid  = v_push[i];
      b_in_data   = 8'(nxt);
      b_out_ready = v_pop[i];
      if (v_pop[i]) begin
        check("b_pop_data", 32'(b_out_data), 32'(exp_rd));
        check("b_pop_valid", 32'(b_out_valid), 1);
      end
      tick();
      if (v_push[i]) begin nxt++; cnt++; end
      if (v_pop[i])  begin exp_rd++; cnt--; end
      check("b_count", 32'(b_count), 32'(cnt));
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("b_drain_data", 32'(b_out_data), 32'(8'h46 + i));
      tick();
    end
    b_out_ready = 1'b0;
    check("b_drained", 32'(b_count), 0);

    // DEPTH=4: fill then drain
    a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_data = 32'(i);
      tick();
    end
    a_in_valid = 1'b0;
    check("fill_count", 32'(a_count), 4);
    check("fill_ready", 32'(a_in_ready), 0);
    check("fill_afull", 32'(a_afull), 1);
    check("fill_aempty", 32'(a_aempty), 0);
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", a_out_data, 32'(i));
      tick();
    end
    a_out_ready = 1'b0;
    check("drain_count", 32'(a_count), 0);
    check("drain_valid", 32'(a_out_valid), 0);

    // simultaneous push/pop at count=2
    a_in_valid = 1'b1;
    a_in_data = 32'd10; tick();
    a_in_data = 32'd11; tick();
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in_data = 32'(12 + i);
      check("pp_data", a_out_data, 32'(10 + i));
      tick();
      check("pp_count", 32'(a_count), 2);
    end
    a_out_ready = 1'b0;
    a_in_data = 32'd17; tick();
    a_in_data = 32'd18; tick();
    check("full2_count", 32'(a_count), 4);

    // full: pop accepted, push refused in the same cycle
    a_in_data = 32'd19; a_out_ready = 1'b1;
    check("full_no_bypass", 32'(a_in_ready), 0);
    check("full_head", a_out_data, 32'd15);
    tick();
    check("full_pop_count", 32'(a_count), 3);
    check("full_pop_head", a_out_data, 32'd16);
    a_out_ready = 1'b0;
    check("retry_ready", 32'(a_in_ready), 1);
    tick();
    a_in_valid = 1'b0;
    check("retry_count", 32'(a_count), 4);
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("retry_drain", a_out_data, 32'(16 + i));
      tick();
    end
    a_out_ready = 1'b0;

    // close with simultaneous push
    a_in_data = 32'd7; a_in_valid = 1'b1; a_in_close = 1'b1;
    tick();
    a_in_valid = 1'b0; a_in_close = 1'b0;
    check("close_valid", 32'(a_out_valid), 1);
    check("close_data", a_out_data, 32'd7);
    check("close_not_drained", 32'(a_out_closed), 0);
    check("close_ready", 32'(a_in_ready), 0);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check("closed_drained", 32'(a_out_closed), 1);
    check("closed_esc_clear", 32'(a_esc), 0);
    a_in_data = 32'd9; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("send_closed_err", 32'(a_esc), 1);
    check("send_closed_drop", 32'(a_count), 0);
    check("edc_clear", 32'(a_edc), 0);
    a_in_close = 1'b1;
    tick();
    a_in_close = 1'b0;
    check("double_close_err", 32'(a_edc), 1);

    // mid-operation reset with count=3, closed, errors set
    rst = 1'b1; tick(); rst = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 32'd1; tick();
    a_in_data = 32'd2; tick();
    a_in_data = 32'd3; a_in_close = 1'b1; tick();
    a_in_close = 1'b0;
    tick();
    a_in_valid = 1'b0;
    a_in_close = 1'b1; tick(); a_in_close = 1'b0;
    check("pre_rst_count", 32'(a_count), 3);
    check("pre_rst_esc", 32'(a_esc), 1);
    check("pre_rst_edc", 32'(a_edc), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_count", 32'(a_count), 0);
    check("mrst_valid", 32'(a_out_valid), 0);
    check("mrst_closed", 32'(a_out_closed), 0);
    check("mrst_ready", 32'(a_in_ready), 1);
    check("mrst_esc", 32'(a_esc), 0);
    check("mrst_edc", 32'(a_edc), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mygo_chan_fifo.md
# mygo_chan_fifo

Parametrised buffered channel for compiled process networks. It generalises the fixed 32-bit, depth-1 channel FIFO to any data width and depth, and adds an occupancy count, almost-full and almost-empty flags, Go-style close semantics (`close(ch)`, receive-side `ok=false`) and sticky error flags for send-after-close and double-close. It sits between a producer process's `chan_*_w*` signals and a consumer process's `chan_*_r*` signals at the top level.

## Interface
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 4, storage entries; any integer ≥1, not limited to powers of two
- AFULL_LVL, DEPTH-1, `almost_full` asserts when count ≥ AFULL_LVL
- AEMPTY_LVL, 1, `almost_empty` asserts when count ≤ AEMPTY_LVL
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  send data
- in_valid  in  1  send request
- in_ready  out  1  send accepted this cycle when high together with in_valid
- in_close  in  1  close request, one-cycle pulse
- out_data  out  WIDTH  head-of-queue data, valid when out_valid is high
- out_valid  out  1  queue non-empty
- out_ready  in  1  receiver pops when high together with out_valid
- out_closed  out  1  closed and drained; receiver sees ok=false
- count  out  $clog2(DEPTH+1)  current occupancy
- almost_full  out  1  occupancy flag
- almost_empty  out  1  occupancy flag
- err_send_closed  out  1  sticky: in_valid seen while closed
- err_double_close  out  1  sticky: in_close seen while already closed

## Operation
- Reset values: count=0, out_valid=0, out_data=0, out_closed=0, closed=0, almost_full=0 (unless AFULL_LVL=0), almost_empty=1, both error flags 0, rd_ptr=wr_ptr=0.
- Push = in_valid && in_ready. The entry is written at wr_ptr, which then increments. Pop = out_valid && out_ready. rd_ptr increments.
- Pointers are $clog2(DEPTH) bits, minimum 1, and wrap from DEPTH-1 to 0 explicitly.
- in_ready = (count < DEPTH) && !closed. Full-state bypass is not supported: when full, in_ready=0 even if a pop occurs in the same cycle. This keeps in_ready free of any combinational path from out_ready.
- out_valid = (count != 0). out_data = mem[rd_ptr]. The queue is first-word-fall-through.
- count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. A simultaneous push and pop is possible only when 0 < count < DEPTH.
- Close handling:
  - in_close while !closed sets closed at the next edge.
  - A push in the same cycle as in_close is accepted. The item is enqueued ahead of the close.
  - After close, remaining entries drain normally.
  - out_closed = closed && count==0.
- Errors:
  - in_valid while closed (closed register already set) sets err_send_closed. The data is dropped.
  - in_close while closed sets err_double_close.
  - Both flags stay set until rst.
- Mid-operation reset discards all contents and clears the closed state.

## Timing
- Push-to-visible latency is 1 cycle. Data pushed at edge N appears on out_data/out_valid after edge N; there is no same-cycle pass-through when empty.
- count, flags, out_closed and the error flags are all registered or derived from registered state, with no input-to-output combinational paths. Exception: out_data mux reads mem[rd_ptr], which is registered state.
- Throughput is 1 push and 1 pop per cycle when not empty and not full.
- DEPTH=1 behaves as the existing depth-1 channel, alternating full and empty.

## Structure
- Package `mygo_chan_pkg` holds:
  - function `mygo_ptr_w(depth)`, returning max(1,$clog2(depth))
  - function `mygo_cnt_w(depth)`, returning $clog2(depth+1)
  - localparam defaults for WIDTH and DEPTH
- Sub-module `mygo_chan_mem`: WIDTH×DEPTH register array with one synchronous write port and one asynchronous read port, no reset on contents.
- Top-level `mygo_chan_fifo` holds pointers, count, closed, error flags and the handshake logic.

## Test plan
- WIDTH=32, DEPTH=4: push 0,1,2,3 with out_ready=0 → count=4, in_ready=0, almost_full=1; then pop 4 → data 0,1,2,3 in order, count=0.
- DEPTH=3 (non-power-of-two): 10 interleaved push/pop cycles with count held at 1–2 → pointers wrap 2→0, data order preserved, no loss.
- Simultaneous push and pop at count=2 for 5 cycles → count stays 2, outputs track the pushed sequence delayed by 2.
- Full with out_ready=1 and in_valid=1 → in_ready=0 that cycle, pop occurs, count=3; next cycle push is accepted.
- Push 7 together with in_close, then pop → out_data=7, out_valid=1; after the pop, out_closed=1. A later in_valid sets err_send_closed; a second in_close sets err_double_close.
- rst asserted at count=3, closed=1 → next cycle count=0, out_valid=0, out_closed=0, in_ready=1, error flags 0.
